// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access; D wins ties.
// Optional statistics counters are built only with MEM_ARB_STATS_EN defined.
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        stall_F,
    output logic        stall_M,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0] conflict_count,
    output logic [31:0] if_grants,
    output logic [31:0] d_grants
`endif
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             own_d_q, own_d_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      if_rdata_q, if_rdata_d;
    logic [31:0]      d_rdata_q, d_rdata_d;
    logic             grant_d, grant_if;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = 1'b0;
        grant_if = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_req) begin
                    grant_d = 1'b1;
                    state_d = ACCESS;
                end else if (if_req) begin
                    grant_if = 1'b1;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request inputs are only looked at on the grant; everything after uses the latched copy.
    always_comb begin
        own_d_d    = own_d_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if (grant_d) begin
            own_d_d = 1'b1;
            we_d    = d_we;
            addr_d  = d_addr;
            wdata_d = d_wdata;
            cnt_d   = CNT_INIT;
        end else if (grant_if) begin
            own_d_d = 1'b0;
            we_d    = 1'b0;
            addr_d  = if_addr;
            cnt_d   = CNT_INIT;
        end
        if (state_q == ACCESS) begin
            if (cnt_q == '0) begin
                if (!own_d_q) begin
                    if_rdata_d = mem_rdata;
                end else if (!we_q) begin
                    d_rdata_d = mem_rdata;
                end
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            own_d_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            own_d_q    <= own_d_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    always_comb begin
        mem_en    = (state_q == ACCESS);
        mem_we    = (state_q == ACCESS) && we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if_ack    = (state_q == RESP) && !own_d_q;
        d_ack     = (state_q == RESP) && own_d_q;
        if_rdata  = if_rdata_q;
        d_rdata   = d_rdata_q;
        stall_F   = if_req && !if_ack;
        stall_M   = d_req && !d_ack;
    end

`ifdef MEM_ARB_STATS_EN
    logic [31:0] conflict_q, conflict_d;
    logic [31:0] if_grants_q, if_grants_d;
    logic [31:0] d_grants_q, d_grants_d;

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        conflict_d  = conflict_q;
        if_grants_d = if_grants_q;
        d_grants_d  = d_grants_q;
        if ((state_q == IDLE) && d_req && if_req && (conflict_q != '1)) begin
            conflict_d = conflict_q + 32'd1;
        end
        if (grant_if && (if_grants_q != '1)) begin
            if_grants_d = if_grants_q + 32'd1;
        end
        if (grant_d && (d_grants_q != '1)) begin
            d_grants_d = d_grants_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_q  <= '0;
            if_grants_q <= '0;
            d_grants_q  <= '0;
        end else begin
            conflict_q  <= conflict_d;
            if_grants_q <= if_grants_d;
            d_grants_q  <= d_grants_d;
        end
    end

    assign conflict_count = conflict_q;
    assign if_grants      = if_grants_q;
    assign d_grants       = d_grants_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, hand sequences, and random traffic vs a timing model.
module tb_mem_port_arbiter;
    localparam int L = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_ack, d_ack, stall_F, stall_M, mem_en, mem_we;

    logic        b_if_req = 1'b0;
    logic [31:0] b_if_addr = '0;
    logic        b_zero = 1'b0;
    logic [31:0] b_zero32 = '0;
    logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_if_ack, b_d_ack, b_stall_F, b_stall_M, b_mem_en, b_mem_we;
    logic        nb_req = 1'b0;
    logic [31:0] nb_addr = '0;
`ifdef MEM_ARB_STATS_EN
    logic [31:0] conflict_count, if_grants, d_grants;
    logic [31:0] b_cc, b_ig, b_dg;
`endif

    mem_port_arbiter #(.MEM_LATENCY(L)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .stall_F(stall_F), .stall_M(stall_M),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef MEM_ARB_STATS_EN
        , .conflict_count(conflict_count), .if_grants(if_grants), .d_grants(d_grants)
`endif
    );

    mem_port_arbiter #(.MEM_LATENCY(1)) dut_b (
        .clk(clk), .reset(reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
        .d_req(b_zero), .d_we(b_zero), .d_addr(b_zero32), .d_wdata(b_zero32),
        .d_rdata(b_d_rdata), .d_ack(b_d_ack), .stall_F(b_stall_F), .stall_M(b_stall_M),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata)
`ifdef MEM_ARB_STATS_EN
        , .conflict_count(b_cc), .if_grants(b_ig), .d_grants(b_dg)
`endif
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        case (a)
            32'h0040_0000: memf = 32'h2402_000A;
            32'h0040_0004: memf = 32'h8C08_0000;
            32'h1001_0000: memf = 32'h1234_5678;
            default:       memf = a ^ 32'hC3C3_0F0F;
        endcase
    endfunction

    assign mem_rdata   = memf(mem_addr);
    assign b_mem_rdata = memf(b_mem_addr);

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got 0x%08h, expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Transaction-level model: an access granted at cycle tg owns the memory for
    // cycles tg+1..tg+L, acks at tg+L+1, and the port is free again from tg+L+2.
    bit          m_valid = 1'b0, m_busy = 1'b0, m_own_d = 1'b0, m_we = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_ird = '0, m_drd = '0;
    int          m_tg = 0, m_cc = 0, m_ig = 0, m_dg = 0;
    logic        e_iack = 1'b0, e_dack = 1'b0;

    task automatic model_check();
        int   d;
        logic e_en, e_ack;
        d     = cyc - m_tg;
        e_en  = m_busy && (d >= 1) && (d <= L);
        e_ack = m_busy && (d == L + 1);
        if (e_ack) begin
            if (!m_own_d) m_ird = memf(m_addr);
            else if (!m_we) m_drd = memf(m_addr);
        end
        e_iack = e_ack && !m_own_d;
        e_dack = e_ack && m_own_d;
        if (m_valid) begin
            chk("mdl mem_en", 32'(mem_en), 32'(e_en));
            chk("mdl mem_we", 32'(mem_we), 32'(e_en && m_we));
            if (e_en) chk("mdl mem_addr", mem_addr, m_addr);
            if (e_en && m_we) chk("mdl mem_wdata", mem_wdata, m_wdata);
            chk("mdl if_ack", 32'(if_ack), 32'(e_iack));
            chk("mdl d_ack", 32'(d_ack), 32'(e_dack));
            chk("mdl if_rdata", if_rdata, m_ird);
            chk("mdl d_rdata", d_rdata, m_drd);
            chk("mdl stall_F", 32'(stall_F), 32'(if_req && !e_iack));
            chk("mdl stall_M", 32'(stall_M), 32'(d_req && !e_dack));
`ifdef MEM_ARB_STATS_EN
            chk("mdl conflict_count", conflict_count, 32'(m_cc));
            chk("mdl if_grants", if_grants, 32'(m_ig));
            chk("mdl d_grants", d_grants, 32'(m_dg));
`endif
        end
    endtask

    task automatic model_update();
        if (reset) begin
            m_valid = 1'b1; m_busy = 1'b0; m_own_d = 1'b0; m_we = 1'b0;
            m_addr = '0; m_wdata = '0; m_ird = '0; m_drd = '0;
            m_cc = 0; m_ig = 0; m_dg = 0;
        end else if (m_busy && (cyc - m_tg == L + 1)) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (d_req && if_req) m_cc++;
            if (d_req) begin
                m_busy = 1'b1; m_own_d = 1'b1; m_we = d_we;
                m_addr = d_addr; m_wdata = d_wdata; m_tg = cyc; m_dg++;
            end else if (if_req) begin
                m_busy = 1'b1; m_own_d = 1'b0; m_we = 1'b0;
                m_addr = if_addr; m_tg = cyc; m_ig++;
            end
        end
    endtask

    task automatic step(input logic rst, input logic ir, input logic [31:0] ia,
                        input logic dr, input logic dw, input logic [31:0] da,
                        input logic [31:0] dwd);
        @(negedge clk);
        reset = rst; if_req = ir; if_addr = ia;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
        b_if_req = nb_req; b_if_addr = nb_addr;
        #1;
        model_check();
        model_update();
        cyc++;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic ih, dh, rst;
        int   base_cc, base_ig, base_dg;
        vecs[0] = '{1'b0, 1'b0, 32'h0040_0000, 32'h0, 32'h2402_000A};
        vecs[1] = '{1'b1, 1'b0, 32'h1001_0000, 32'h0, 32'h1234_5678};
        vecs[2] = '{1'b1, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 32'h1234_5678};
        vecs[3] = '{1'b0, 1'b0, 32'h0040_0004, 32'h0, 32'h8C08_0000};
        vecs[4] = '{1'b1, 1'b0, 32'h2000_0010, 32'h0, 32'hE3C3_0F1F};

        for (int i = 0; i < 2; i++)
            step(1'b1, 1'($urandom), $urandom, 1'($urandom), 1'($urandom), $urandom, $urandom);
        idle();
        chk("rst mem_en", 32'(mem_en), 32'h0);
        chk("rst mem_we", 32'(mem_we), 32'h0);
        chk("rst mem_addr", mem_addr, 32'h0);
        chk("rst mem_wdata", mem_wdata, 32'h0);
        chk("rst if_ack", 32'(if_ack), 32'h0);
        chk("rst d_ack", 32'(d_ack), 32'h0);
        chk("rst if_rdata", if_rdata, 32'h0);
        chk("rst d_rdata", d_rdata, 32'h0);
        chk("rst b_mem_en", 32'(b_mem_en), 32'h0);
`ifdef MEM_ARB_STATS_EN
        chk("rst conflict_count", conflict_count, 32'h0);
        chk("rst if_grants", if_grants, 32'h0);
        chk("rst d_grants", d_grants, 32'h0);
`endif

        foreach (vecs[v]) begin
            for (int k = 0; k <= L + 1; k++) begin
                step(1'b0, !vecs[v].is_d, vecs[v].addr, vecs[v].is_d, vecs[v].we,
                     vecs[v].addr, vecs[v].wdata);
                chk("vec mem_en", 32'(mem_en), 32'(k >= 1 && k <= L));
                if (k >= 1 && k <= L) begin
                    chk("vec mem_addr", mem_addr, vecs[v].addr);
                    chk("vec mem_we", 32'(mem_we), 32'(vecs[v].we));
                    if (vecs[v].we) chk("vec mem_wdata", mem_wdata, vecs[v].wdata);
                end
                chk("vec ack", 32'(vecs[v].is_d ? d_ack : if_ack), 32'(k == L + 1));
                chk("vec stall", 32'(vecs[v].is_d ? stall_M : stall_F), 32'(k <= L));
                if (k == L + 1)
                    chk("vec rdata", vecs[v].is_d ? d_rdata : if_rdata, vecs[v].exp_rdata);
            end
            idle();
        end

        // Both requests rise together: D first, IF picked up at the next IDLE.
        base_cc = m_cc; base_ig = m_ig; base_dg = m_dg;
        for (int k = 0; k <= 8; k++) begin
            step(1'b0, 1'(k <= 7), 32'h0040_0000, 1'(k <= 3), 1'b0, 32'h1001_0000, 32'h0);
            chk("cfl d_ack", 32'(d_ack), 32'(k == 3));
            chk("cfl if_ack", 32'(if_ack), 32'(k == 7));
            chk("cfl stall_F", 32'(stall_F), 32'(k <= 6));
            chk("cfl mem_en", 32'(mem_en), 32'(k == 1 || k == 2 || k == 5 || k == 6));
            if (k == 5 || k == 6) chk("cfl mem_addr", mem_addr, 32'h0040_0000);
            if (k == 3) chk("cfl d_rdata", d_rdata, 32'h1234_5678);
            if (k == 7) chk("cfl if_rdata", if_rdata, 32'h2402_000A);
        end
`ifdef MEM_ARB_STATS_EN
        chk("cfl conflict_count", conflict_count, 32'(base_cc + 1));
        chk("cfl if_grants", if_grants, 32'(base_ig + 1));
        chk("cfl d_grants", d_grants, 32'(base_dg + 1));
`endif

        // Reset lands in the last access cycle of a load; the transaction is dropped.
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1001_0000, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1001_0000, 32'h0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1001_0000, 32'h0);
        chk("rma mem_en before reset edge", 32'(mem_en), 32'h1);
        idle();
        chk("rma mem_en", 32'(mem_en), 32'h0);
        chk("rma d_ack", 32'(d_ack), 32'h0);
        chk("rma d_rdata", d_rdata, 32'h0);
        for (int j = 0; j <= L + 1; j++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1001_0000, 32'h0);
            chk("rma reissue d_ack", 32'(d_ack), 32'(j == L + 1));
            if (j == L + 1) chk("rma reissue d_rdata", d_rdata, 32'h1234_5678);
        end
        idle();

        // Latency-1 instance: fetch address changes mid-access and must be ignored.
        nb_req = 1'b1; nb_addr = 32'h0040_0000;
        idle();
        chk("lat1 c0 mem_en", 32'(b_mem_en), 32'h0);
        chk("lat1 c0 stall_F", 32'(b_stall_F), 32'h1);
        nb_addr = 32'h0040_0004;
        idle();
        chk("lat1 c1 mem_en", 32'(b_mem_en), 32'h1);
        chk("lat1 c1 mem_addr", b_mem_addr, 32'h0040_0000);
        chk("lat1 c1 if_ack", 32'(b_if_ack), 32'h0);
        idle();
        chk("lat1 c2 if_ack", 32'(b_if_ack), 32'h1);
        chk("lat1 c2 if_rdata", b_if_rdata, 32'h2402_000A);
        chk("lat1 c2 mem_en", 32'(b_mem_en), 32'h0);
        chk("lat1 c2 stall_F", 32'(b_stall_F), 32'h0);
        nb_req = 1'b0;
        idle();
        chk("lat1 c3 if_ack", 32'(b_if_ack), 32'h0);

        ih = 1'b0; dh = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (ih) begin
                if (e_iack) ih = 1'($urandom_range(0, 1));
            end else begin
                ih = ($urandom_range(0, 2) == 0);
            end
            if (dh) begin
                if (e_dack) dh = 1'($urandom_range(0, 1));
            end else begin
                dh = ($urandom_range(0, 2) == 0);
            end
            rst = ($urandom_range(0, 149) == 0);
            step(rst, ih, $urandom, dh, 1'($urandom), $urandom, $urandom);
        end
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
